// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller over a one-byte UART receiver: header/length/payload/checksum
// parsing with timeout, then replay of the buffered payload on a valid/ready stream.
module uart_rx_frame_ctrl #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       byte_rx_en,
    input  logic [7:0] byte_data,
    input  logic       byte_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [2:0] state
);

    localparam int unsigned TIMEOUT_CYC = (CLK_FREQ / BAUD_RATE) * 10 * TIMEOUT_BYTES;
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);
    localparam int unsigned AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH       = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d, idx_q, idx_d, csum_q, csum_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  out_data_q;
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic        frame_ok_q, frame_ok_d, err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        byte_rx_en_q, busy_q;
    logic        wr_en, rd_en, tmo_hit;
    logic [7:0]  rd_idx;

    logic [7:0]  buf_mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = idx_q;
        // A byte arriving on the expiry cycle takes priority over the timeout.
        tmo_hit     = (tmo_q == TMO_LAST) && !byte_done;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_HDR;
            end
            S_HDR: begin
                if (!enable) state_d = S_IDLE;
                else if (byte_done && byte_data == HEADER) state_d = S_LEN;
            end
            S_LEN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (byte_done) begin
                    if (byte_data == 8'd0 || byte_data > MAX_LEN_B) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_HDR;
                    end else begin
                        len_d   = byte_data;
                        csum_d  = byte_data;
                        idx_d   = 8'd0;
                        state_d = S_DATA;
                    end
                end else if (tmo_hit) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd3;
                    state_d     = S_HDR;
                end
            end
            S_DATA: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (byte_done) begin
                    wr_en  = 1'b1;
                    csum_d = csum_q + byte_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) state_d = S_CSUM;
                end else if (tmo_hit) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd3;
                    state_d     = S_HDR;
                end
            end
            S_CSUM: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (byte_done) begin
                    if (byte_data != csum_q) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = S_HDR;
                    end else begin
                        idx_d   = 8'd0;
                        state_d = S_OUT;
                    end
                end else if (tmo_hit) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd3;
                    state_d     = S_HDR;
                end
            end
            S_OUT: begin
                // First cycle fetches byte 0; each handshake prefetches the next.
                if (!out_valid_q) begin
                    rd_en       = 1'b1;
                    rd_idx      = idx_q;
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == len_q - 8'd1);
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        frame_ok_d  = 1'b1;
                        state_d     = enable ? S_HDR : S_IDLE;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        rd_en      = 1'b1;
                        rd_idx     = idx_q + 8'd1;
                        out_last_d = (idx_q + 8'd1 == len_q - 8'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || byte_done)
            tmo_d = 32'd0;
        else if (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM)
            tmo_d = tmo_q + 32'd1;
        else
            tmo_d = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[idx_q[AW-1:0]] <= byte_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= 8'd0;
            idx_q        <= 8'd0;
            csum_q       <= 8'd0;
            tmo_q        <= 32'd0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 2'd0;
            byte_rx_en_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            if (rd_en) out_data_q <= buf_mem[rd_idx[AW-1:0]];
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_ok_q   <= frame_ok_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            byte_rx_en_q <= (state_d == S_HDR) || (state_d == S_LEN) ||
                            (state_d == S_DATA) || (state_d == S_CSUM);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_HDR);
        end
    end

    assign byte_rx_en = byte_rx_en_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_ok   = frame_ok_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;
    assign state      = state_q;

endmodule
